// File: rtl/p4_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : p4_mem_pkg
//  Description : Shared widths, default IO address and memory-operation
//                encodings for the memory-access stage of the 16-bit pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package p4_mem_pkg;

    localparam int          c_data_w          = 16;
    localparam int          c_reg_w           = 3;
    localparam logic [15:0] c_io_addr_default = 16'hFFFF;

    // Memory operation requested by the execute stage.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_e;

endpackage : p4_mem_pkg
`default_nettype wire

// File: rtl/p4_dram.sv
`default_nettype none
// ============================================================================
//  Module      : p4_dram
//  Description : Single-port synchronous data RAM, write-first read port.
//                Written in the plain form that maps onto block RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module p4_dram
    import p4_mem_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [c_data_w-1:0] i_wdata,
    output logic [c_data_w-1:0] o_rdata
);

    logic [c_data_w-1:0] r_mem [DEPTH];
    logic [c_data_w-1:0] r_rdata;

    // Write-first port: a write returns the new data on the read port.
    // No reset so the array and output register stay block-RAM friendly.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_rdata       <= i_wdata;
        end else begin
            r_rdata       <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : p4_dram
`default_nettype wire

// File: rtl/p4_mem.sv
`default_nettype none
// ============================================================================
//  Module      : p4_mem
//  Description : Memory-access pipeline stage. Owns the data RAM, one
//                memory-mapped output register and a sticky address-error
//                flag; delivers registered writeback controls and data.
//  Revision    : 1.0  initial release
// ============================================================================
module p4_mem
    import p4_mem_pkg::*;
#(
    parameter int          DEPTH   = 2048,
    parameter int          ADDR_W  = 11,   // 2**ADDR_W must equal DEPTH
    parameter logic [15:0] IO_ADDR = c_io_addr_default
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_data_w-1:0] aluOutput,
    input  logic                writeRegp3,
    input  logic [c_reg_w-1:0]  regAddressp3,
    input  logic [c_data_w-1:0] Address,
    input  logic [c_data_w-1:0] storeData,
    input  logic                writeEnable,
    input  logic                readEnable,
    output logic                writeRegp4,
    output logic [c_reg_w-1:0]  regAddressp4,
    output logic [c_data_w-1:0] writeDatap4,
    output logic [c_data_w-1:0] ioOut,
    output logic                ioValid,
    output logic                addrError
);

    localparam logic [c_data_w:0] c_depth_ext = (c_data_w+1)'(DEPTH);

    // Pipeline and status registers
    logic                r_write_reg;
    logic [c_reg_w-1:0]  r_reg_addr;
    logic [c_data_w-1:0] r_alu;
    logic                r_load_sel;     // previous cycle was a load
    logic                r_load_ram;     // load data comes from the RAM port
    logic [c_data_w-1:0] r_load_alt;     // load data for non-RAM sources
    logic [c_data_w-1:0] r_io_out;
    logic                r_io_valid;
    logic                r_addr_err;

    // Next-state values
    logic                w_load_sel_nxt;
    logic                w_load_ram_nxt;
    logic [c_data_w-1:0] w_load_alt_nxt;
    logic [c_data_w-1:0] w_io_out_nxt;
    logic                w_io_valid_nxt;
    logic                w_addr_err_nxt;

    logic                w_in_range;
    logic                w_is_io;
    logic                w_both;
    logic                w_ram_we;
    mem_op_e             w_op;
    logic [c_data_w-1:0] w_ram_rdata;

    assign w_in_range = ({1'b0, Address} < c_depth_ext);
    assign w_is_io    = (Address == IO_ADDR);
    // The illegal both-enables encoding is executed as a store that also
    // returns the stored value as load data.
    assign w_both     = writeEnable & readEnable;
    assign w_op       = writeEnable ? MEM_WRITE :
                        readEnable  ? MEM_READ  : MEM_NONE;
    // RAM write is gated by reset so a store coinciding with reset is dropped.
    assign w_ram_we   = (w_op == MEM_WRITE) & w_in_range & ~reset;

    p4_dram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (Address[ADDR_W-1:0]),
        .i_wdata (storeData),
        .o_rdata (w_ram_rdata)
    );

    // Decode the memory operation into next values for IO, error and load path.
    always_comb begin
        w_load_sel_nxt = 1'b0;
        w_load_ram_nxt = 1'b0;
        w_load_alt_nxt = '0;
        w_io_out_nxt   = r_io_out;
        w_io_valid_nxt = 1'b0;
        w_addr_err_nxt = r_addr_err;
        case (w_op)
            MEM_WRITE: begin
                if (!w_in_range) begin
                    if (w_is_io) begin
                        w_io_out_nxt   = storeData;
                        w_io_valid_nxt = 1'b1;
                    end else begin
                        w_addr_err_nxt = 1'b1;
                    end
                end
                if (w_both) begin
                    w_load_sel_nxt = 1'b1;
                    // In range the write-first RAM port already returns storeData.
                    w_load_ram_nxt = w_in_range;
                    w_load_alt_nxt = storeData;
                end
            end
            MEM_READ: begin
                w_load_sel_nxt = 1'b1;
                if (w_in_range) begin
                    w_load_ram_nxt = 1'b1;
                end else if (w_is_io) begin
                    w_load_alt_nxt = r_io_out;
                end else begin
                    w_addr_err_nxt = 1'b1;
                end
            end
            default: begin
                w_load_sel_nxt = 1'b0;
            end
        endcase
    end

    // Stage registers; reset discards any access presented with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_reg <= 1'b0;
            r_reg_addr  <= '0;
            r_alu       <= '0;
            r_load_sel  <= 1'b0;
            r_load_ram  <= 1'b0;
            r_load_alt  <= '0;
            r_io_out    <= '0;
            r_io_valid  <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_write_reg <= writeRegp3;
            r_reg_addr  <= regAddressp3;
            r_alu       <= aluOutput;
            r_load_sel  <= w_load_sel_nxt;
            r_load_ram  <= w_load_ram_nxt;
            r_load_alt  <= w_load_alt_nxt;
            r_io_out    <= w_io_out_nxt;
            r_io_valid  <= w_io_valid_nxt;
            r_addr_err  <= w_addr_err_nxt;
        end
    end

    assign writeRegp4   = r_write_reg;
    assign regAddressp4 = r_reg_addr;
    assign writeDatap4  = r_load_sel ? (r_load_ram ? w_ram_rdata : r_load_alt) : r_alu;
    assign ioOut        = r_io_out;
    assign ioValid      = r_io_valid;
    assign addrError    = r_addr_err;

endmodule : p4_mem
`default_nettype wire

// File: tb/tb_p4_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_p4_mem
//  Description : Self-checking bench for p4_mem: a table of directed vectors
//                with hand-computed expectations plus short corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_p4_mem;

    logic        clk;
    logic        reset;
    logic [15:0] aluOutput;
    logic        writeRegp3;
    logic [2:0]  regAddressp3;
    logic [15:0] Address;
    logic [15:0] storeData;
    logic        writeEnable;
    logic        readEnable;
    logic        writeRegp4;
    logic [2:0]  regAddressp4;
    logic [15:0] writeDatap4;
    logic [15:0] ioOut;
    logic        ioValid;
    logic        addrError;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [15:0] sd;
        logic [15:0] alu;
        logic        wr;
        logic [2:0]  ra;
        logic        e_wr;
        logic [2:0]  e_ra;
        logic [15:0] e_wd;
        logic [15:0] e_io;
        logic        e_iov;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    p4_mem #(
        .DEPTH   (2048),
        .ADDR_W  (11),
        .IO_ADDR (16'hFFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .aluOutput    (aluOutput),
        .writeRegp3   (writeRegp3),
        .regAddressp3 (regAddressp3),
        .Address      (Address),
        .storeData    (storeData),
        .writeEnable  (writeEnable),
        .readEnable   (readEnable),
        .writeRegp4   (writeRegp4),
        .regAddressp4 (regAddressp4),
        .writeDatap4  (writeDatap4),
        .ioOut        (ioOut),
        .ioValid      (ioValid),
        .addrError    (addrError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic push(input logic rst, input logic we, input logic re, input logic [15:0] addr,
                        input logic [15:0] sd, input logic [15:0] alu, input logic wr, input logic [2:0] ra,
                        input logic e_wr, input logic [2:0] e_ra, input logic [15:0] e_wd,
                        input logic [15:0] e_io, input logic e_iov, input logic e_err);
        vec_t v;
        v.rst = rst; v.we = we; v.re = re; v.addr = addr; v.sd = sd; v.alu = alu;
        v.wr = wr; v.ra = ra; v.e_wr = e_wr; v.e_ra = e_ra; v.e_wd = e_wd;
        v.e_io = e_io; v.e_iov = e_iov; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, check 1 ns after it.
    task automatic step(input logic rst, input logic we, input logic re, input logic [15:0] addr,
                        input logic [15:0] sd, input logic [15:0] alu, input logic wr, input logic [2:0] ra);
        reset = rst; writeEnable = we; readEnable = re; Address = addr; storeData = sd;
        aluOutput = alu; writeRegp3 = wr; regAddressp3 = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic e_wr, input logic [2:0] e_ra, input logic [15:0] e_wd,
                             input logic [15:0] e_io, input logic e_iov, input logic e_err);
        chk("writeRegp4",   idx, {15'd0, writeRegp4},   {15'd0, e_wr});
        chk("regAddressp4", idx, {13'd0, regAddressp4}, {13'd0, e_ra});
        chk("writeDatap4",  idx, writeDatap4,           e_wd);
        chk("ioOut",        idx, ioOut,                 e_io);
        chk("ioValid",      idx, {15'd0, ioValid},      {15'd0, e_iov});
        chk("addrError",    idx, {15'd0, addrError},    {15'd0, e_err});
    endtask

    initial begin
        //     rst we re addr      sd        alu       wr ra  | e_wr e_ra e_wd      e_io      iov err
        push(1, 1, 0, 16'h0010, 16'hAAAA, 16'h1234, 1, 3,   0, 0, 16'h0000, 16'h0000, 0, 0); // 0 reset, store dropped
        push(1, 0, 0, 16'h0000, 16'h0000, 16'h1234, 1, 3,   0, 0, 16'h0000, 16'h0000, 0, 0); // 1 reset held
        push(0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 1, 3,   1, 3, 16'h1234, 16'h0000, 0, 0); // 2 idle pass-through
        push(0, 1, 0, 16'h0010, 16'hBEEF, 16'h0001, 0, 0,   0, 0, 16'h0001, 16'h0000, 0, 0); // 3 store BEEF
        push(0, 0, 1, 16'h0010, 16'h0000, 16'h0002, 1, 5,   1, 5, 16'hBEEF, 16'h0000, 0, 0); // 4 load it back
        push(0, 1, 0, 16'hFFFF, 16'h00A5, 16'h0003, 0, 1,   0, 1, 16'h0003, 16'h00A5, 1, 0); // 5 IO store
        push(0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 2,   0, 2, 16'h0004, 16'h00A5, 0, 0); // 6 pulse ends
        push(0, 0, 1, 16'hFFFF, 16'h0000, 16'h0005, 1, 7,   1, 7, 16'h00A5, 16'h00A5, 0, 0); // 7 IO load
        push(0, 1, 0, 16'hFFFF, 16'h1111, 16'h0006, 0, 0,   0, 0, 16'h0006, 16'h1111, 1, 0); // 8 IO store
        push(0, 1, 0, 16'hFFFF, 16'h2222, 16'h0007, 0, 0,   0, 0, 16'h0007, 16'h2222, 1, 0); // 9 back-to-back
        push(0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 0, 0,   0, 0, 16'h0008, 16'h2222, 0, 0); // 10 idle
        push(0, 1, 0, 16'h0100, 16'hCAFE, 16'h0009, 0, 0,   0, 0, 16'h0009, 16'h2222, 0, 0); // 11 store CAFE
        push(0, 1, 0, 16'h0900, 16'h9999, 16'h000A, 0, 0,   0, 0, 16'h000A, 16'h2222, 0, 1); // 12 out-of-range store
        push(0, 0, 1, 16'h0900, 16'h0000, 16'h000B, 0, 0,   0, 0, 16'h0000, 16'h2222, 0, 1); // 13 out-of-range load
        push(0, 0, 1, 16'h0100, 16'h0000, 16'h000C, 0, 0,   0, 0, 16'hCAFE, 16'h2222, 0, 1); // 14 alias not written
        push(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0000, 16'h2222, 0, 1); // 15 sticky error
        push(0, 1, 0, 16'h0020, 16'h1357, 16'h000D, 0, 0,   0, 0, 16'h000D, 16'h2222, 0, 1); // 16 store 1357
        push(1, 1, 0, 16'h0020, 16'h5555, 16'h000E, 1, 1,   0, 0, 16'h0000, 16'h0000, 0, 0); // 17 reset + store
        push(0, 0, 1, 16'h0020, 16'h0000, 16'h000F, 1, 4,   1, 4, 16'h1357, 16'h0000, 0, 0); // 18 old value
        push(0, 1, 1, 16'h0030, 16'h7777, 16'h0005, 0, 0,   0, 0, 16'h7777, 16'h0000, 0, 0); // 19 both enables
        push(0, 0, 0, 16'h0000, 16'h0000, 16'h0006, 1, 6,   1, 6, 16'h0006, 16'h0000, 0, 0); // 20 idle
        push(0, 0, 1, 16'h0030, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h7777, 16'h0000, 0, 0); // 21 load 7777
        push(0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'hBEEF, 16'h0000, 0, 0); // 22 survives reset

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].sd,
                 vecs[i].alu, vecs[i].wr, vecs[i].ra);
            check_all(i, vecs[i].e_wr, vecs[i].e_ra, vecs[i].e_wd, vecs[i].e_io, vecs[i].e_iov, vecs[i].e_err);
        end

        // Both enables to an out-of-range address: error set, storeData returned.
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        check_all(100, 0, 0, 16'h0000, 16'h0000, 0, 0);
        step(0, 1, 1, 16'h0900, 16'h4242, 16'h0011, 0, 0);
        check_all(101, 0, 0, 16'h4242, 16'h0000, 0, 1);

        // Address == DEPTH is the first out-of-range word.
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        step(0, 1, 0, 16'h0800, 16'h0DEF, 16'h0012, 0, 0);
        check_all(102, 0, 0, 16'h0012, 16'h0000, 0, 1);

        // Address == DEPTH-1 is the last in-range word.
        step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        step(0, 1, 0, 16'h07FF, 16'h0ABC, 16'h0013, 0, 0);
        check_all(103, 0, 0, 16'h0013, 16'h0000, 0, 0);
        step(0, 0, 1, 16'h07FF, 16'h0000, 16'h0014, 1, 2);
        check_all(104, 1, 2, 16'h0ABC, 16'h0000, 0, 0);

        // Both enables to the IO address: ioOut and load data both take storeData.
        step(0, 1, 1, 16'hFFFF, 16'h3C3C, 16'h0015, 0, 0);
        check_all(105, 0, 0, 16'h3C3C, 16'h3C3C, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_p4_mem
`default_nettype wire

// File: doc/p4_mem.md
Name: p4_mem

Overview:
- Memory-access stage of the 16-bit pipeline; the receiving end of the execute stage's memory/writeback interface.
- Consumes the ALU result, store address/data, read/write enables and register-write controls.
- Owns the data RAM and one memory-mapped output register.
- Delivers registered writeback controls and writeback data to the register-file stage.

Parameters:
DEPTH, 2048, data RAM depth in 16-bit words
ADDR_W, 11, RAM index width; must satisfy 2**ADDR_W == DEPTH
IO_ADDR, 16'hFFFF, address of the memory-mapped output register

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
aluOutput  in  16  ALU result from execute stage
writeRegp3  in  1  register-write request from execute stage
regAddressp3  in  3  destination register from execute stage
Address  in  16  load/store address
storeData  in  16  store data
writeEnable  in  1  store request
readEnable  in  1  load request
writeRegp4  out  1  registered register-write request
regAddressp4  out  3  registered destination register
writeDatap4  out  16  writeback data: load data if the previous cycle was a load, else registered ALU result
ioOut  out  16  memory-mapped output register
ioValid  out  1  one-cycle pulse on each write to IO_ADDR
addrError  out  1  sticky out-of-range access flag

Behaviour:
- Reset (synchronous, active-high) clears writeRegp4, regAddressp4, the ALU hold register, the load-select flag, the load data register, ioOut, ioValid and addrError. writeDatap4 therefore reads 0 after reset. RAM contents are not cleared.
- A write or read presented in the same cycle as reset is suppressed: no RAM or ioOut update, no flag set.
- Latency is one clock. Inputs sampled at edge N appear on writeRegp4, regAddressp4 and writeDatap4 after edge N, valid throughout cycle N+1.
- In-range test: Address < DEPTH. RAM index = Address[ADDR_W-1:0].
- Store (writeEnable=1, readEnable=0):
  - In range: mem[index] <= storeData at the edge.
  - Address == IO_ADDR: ioOut <= storeData and ioValid=1 for the next cycle only. RAM untouched.
  - Any other address: no write; addrError <= 1.
- Load (readEnable=1, writeEnable=0):
  - Load data register <= mem[index] (synchronous read) and load-select <= 1.
  - Address == IO_ADDR: load data = ioOut.
  - Any other out-of-range address: load data = 0; addrError <= 1.
- Neither enable set: load-select <= 0, and writeDatap4 = registered aluOutput.
- Both enables set (illegal encoding): treated as a store, with write-first semantics. load-select <= 1 and load data = storeData. addrError is unaffected unless the address is out of range.
- Store then load to the same address on consecutive cycles returns the new value; no hazard logic is required.
- writeRegp4 and regAddressp4 are pure one-stage delays. Load data never alters them.
- addrError stays set until reset.
- ioValid is 0 on every cycle not directly following an IO_ADDR store. Back-to-back IO stores keep it high and update ioOut each cycle.
- writeDatap4 is a combinational mux of two registers: load-select chooses load data, otherwise the ALU hold register. There is no combinational path from any input to any output.

Decomposition:
- Shared package: data width 16, register-address width 3, IO_ADDR default, and memWrite encodings (1 = read, 2 = write).
- One natural sub-module, p4_dram: single-port synchronous RAM with write-first read, parameterised by DEPTH/ADDR_W. It must infer block RAM.
- The stage logic, IO register and error flag stay in p4_mem.

Test Plan:
- Reset, then idle with aluOutput=16'h1234, writeRegp3=1, regAddressp3=3 → one cycle later writeDatap4=16'h1234, writeRegp4=1, regAddressp4=3; all outputs 0 while reset is held.
- Store 16'hBEEF to Address 16'h0010, then load from 16'h0010 next cycle → writeDatap4=16'hBEEF in the cycle after the load.
- Store 16'h00A5 to 16'hFFFF → ioOut=16'h00A5 and ioValid=1 for exactly one cycle; a load from 16'hFFFF then returns 16'h00A5.
- Store to 16'h0900 (DEPTH=2048) → addrError=1 and stays 1; a subsequent load from 16'h0900 returns 0; mem[16'h0100] is unchanged.
- Assert reset concurrently with a store of 16'h5555 to 16'h0020, then load 16'h0020 → the old value is returned; addrError and ioValid remain 0.
- Both enables high, storeData=16'h7777, Address 16'h0030 → writeDatap4=16'h7777 next cycle, and a later load from 16'h0030 returns 16'h7777.
